// File: rtl/dot_product_pkg.sv
// Shared types and default sizing for the dot-product feeder and dotProduct.
package dot_product_pkg;

  localparam int DP_DATA_WIDTH   = 8;
  localparam int DP_VECTOR_WIDTH = 4;
  localparam int DP_ADDR_WIDTH   = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    READ     = 2'd1,
    WAIT_RES = 2'd2,
    DONE     = 2'd3
  } dp_state_e;

  // Full-precision width of a sum of vw products of two dw-bit operands.
  function automatic int dp_result_width(input int dw, input int vw);
    return 2 * dw + $clog2(vw);
  endfunction

  localparam int DP_RESULT_WIDTH = dp_result_width(DP_DATA_WIDTH, DP_VECTOR_WIDTH);

endpackage

// File: rtl/dot_product_addr_gen.sv
// Vector-memory read sequencer: per-vector base addresses, element counter,
// shared read strobe and the 2-cycle alignment pipeline towards dotProduct.
module dot_product_addr_gen
  import dot_product_pkg::*;
#(
  parameter int DATA_WIDTH   = DP_DATA_WIDTH,
  parameter int VECTOR_WIDTH = DP_VECTOR_WIDTH,
  parameter int ADDR_WIDTH   = DP_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic                  issue_i,
  input  logic                  advance_i,
  input  logic [ADDR_WIDTH-1:0] base1_i,
  input  logic [ADDR_WIDTH-1:0] base2_i,
  input  logic [DATA_WIDTH-1:0] mem1_rdata_i,
  input  logic [DATA_WIDTH-1:0] mem2_rdata_i,
  output logic                  mem_rd_en_o,
  output logic [ADDR_WIDTH-1:0] mem1_addr_o,
  output logic [ADDR_WIDTH-1:0] mem2_addr_o,
  output logic [DATA_WIDTH-1:0] mem1_output_o,
  output logic [DATA_WIDTH-1:0] mem2_output_o,
  output logic                  data_valid_o,
  output logic                  burst_last_o
);

  localparam int EW = $clog2(VECTOR_WIDTH) + 1;

  logic [ADDR_WIDTH-1:0] base1_q, base2_q;
  logic [EW-1:0]         elem_q;
  logic                  rd_en_q;
  logic                  rd_d1_q;
  logic                  dv_q;
  logic [DATA_WIDTH-1:0] out1_q, out2_q;

  // Addresses are formed from registers only, so they are stable for the whole cycle.
  assign mem_rd_en_o   = rd_en_q;
  assign mem1_addr_o   = base1_q + ADDR_WIDTH'(elem_q);
  assign mem2_addr_o   = base2_q + ADDR_WIDTH'(elem_q);
  assign burst_last_o  = rd_en_q && (elem_q == EW'(VECTOR_WIDTH - 1));
  assign mem1_output_o = out1_q;
  assign mem2_output_o = out2_q;
  assign data_valid_o  = dv_q;

  // Vector base registers: latched on a new command, stepped one vector per result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base1_q <= '0;
      base2_q <= '0;
    end else if (load_i) begin
      base1_q <= base1_i;
      base2_q <= base2_i;
    end else if (advance_i) begin
      base1_q <= base1_q + ADDR_WIDTH'(VECTOR_WIDTH);
      base2_q <= base2_q + ADDR_WIDTH'(VECTOR_WIDTH);
    end
  end

  // Read burst: one strobe per element, VECTOR_WIDTH back-to-back cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_en_q <= 1'b0;
      elem_q  <= '0;
    end else if (issue_i) begin
      rd_en_q <= 1'b1;
      elem_q  <= '0;
    end else if (rd_en_q) begin
      if (burst_last_o) begin
        rd_en_q <= 1'b0;
        elem_q  <= '0;
      end else begin
        elem_q <= elem_q + EW'(1);
      end
    end
  end

  // Alignment pipeline: read data lands one cycle after the strobe and is registered once more.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_d1_q <= 1'b0;
      dv_q    <= 1'b0;
      out1_q  <= '0;
      out2_q  <= '0;
    end else begin
      rd_d1_q <= rd_en_q;
      dv_q    <= rd_d1_q;
      if (rd_d1_q) begin
        out1_q <= mem1_rdata_i;
        out2_q <= mem2_rdata_i;
      end
    end
  end

endmodule

// File: rtl/dot_product_feeder.sv
// Initiator for dotProduct: sequences vector reads, collects results and
// reports completion or a result timeout upstream.
module dot_product_feeder
  import dot_product_pkg::*;
#(
  parameter int DATA_WIDTH     = DP_DATA_WIDTH,
  parameter int VECTOR_WIDTH   = DP_VECTOR_WIDTH,
  parameter int ADDR_WIDTH     = DP_ADDR_WIDTH,
  parameter int RESULT_WIDTH   = dp_result_width(DATA_WIDTH, VECTOR_WIDTH),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr1,
  input  logic [ADDR_WIDTH-1:0]   base_addr2,
  input  logic [ADDR_WIDTH-1:0]   num_vectors,
  output logic                    mem_rd_en,
  output logic [ADDR_WIDTH-1:0]   mem1_addr,
  output logic [ADDR_WIDTH-1:0]   mem2_addr,
  input  logic [DATA_WIDTH-1:0]   mem1_rdata,
  input  logic [DATA_WIDTH-1:0]   mem2_rdata,
  output logic [DATA_WIDTH-1:0]   mem1_output,
  output logic [DATA_WIDTH-1:0]   mem2_output,
  output logic                    data_valid,
  input  logic [RESULT_WIDTH-1:0] dot_product_result,
  input  logic                    result_valid,
  output logic [RESULT_WIDTH-1:0] result_out,
  output logic                    result_out_valid,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  dp_state_e             state_q;
  logic [ADDR_WIDTH-1:0] nv_q;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic [RESULT_WIDTH-1:0] result_q;
  logic                  rov_q, done_q, busy_q, error_q;

  logic load, issue, advance, burst_last, got_result;

  // Sequencer controls derived from the current state and this cycle's inputs.
  always_comb begin
    got_result = (state_q == WAIT_RES) && result_valid;
    load       = (state_q == IDLE) && start && (num_vectors != '0);
    advance    = got_result;
    issue      = load || (got_result && (nv_q != ADDR_WIDTH'(1)));
    tmo_d      = tmo_q + TW'(1);
  end

  dot_product_addr_gen #(
    .DATA_WIDTH   (DATA_WIDTH),
    .VECTOR_WIDTH (VECTOR_WIDTH),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_addr_gen (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_i        (load),
    .issue_i       (issue),
    .advance_i     (advance),
    .base1_i       (base_addr1),
    .base2_i       (base_addr2),
    .mem1_rdata_i  (mem1_rdata),
    .mem2_rdata_i  (mem2_rdata),
    .mem_rd_en_o   (mem_rd_en),
    .mem1_addr_o   (mem1_addr),
    .mem2_addr_o   (mem2_addr),
    .mem1_output_o (mem1_output),
    .mem2_output_o (mem2_output),
    .data_valid_o  (data_valid),
    .burst_last_o  (burst_last)
  );

  assign result_out       = result_q;
  assign result_out_valid = rov_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign error            = error_q;

  // Command FSM with registered status outputs; result takes priority over timeout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      nv_q     <= '0;
      tmo_q    <= '0;
      result_q <= '0;
      rov_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      rov_q  <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            error_q <= 1'b0;
            busy_q  <= 1'b1;
            if (num_vectors != '0) begin
              nv_q    <= num_vectors;
              state_q <= READ;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        READ: begin
          if (burst_last) begin
            state_q <= WAIT_RES;
            tmo_q   <= '0;
          end
        end
        WAIT_RES: begin
          tmo_q <= tmo_d;
          if (result_valid) begin
            result_q <= dot_product_result;
            rov_q    <= 1'b1;
            nv_q     <= nv_q - ADDR_WIDTH'(1);
            if (nv_q == ADDR_WIDTH'(1)) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= READ;
            end
          end else if (tmo_d == TW'(TIMEOUT_CYCLES)) begin
            error_q <= 1'b1;
            state_q <= DONE;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
